// File: rtl/dsa_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// DSA_SUB_EN (optional) adds a subtract-select input; see digit_serial_adder.sv.
package dsa_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // A single-digit adder still needs a one-bit counter so the index logic stays uniform.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// The sub field exists only when DSA_SUB_EN is defined.
interface digit_serial_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef DSA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef DSA_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
`ifdef DSA_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/digit_rca.sv
// Combinational DIGIT-bit ripple-carry slice reused every cycle by the serial adder.
module digit_rca #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             ci_i,
  output logic [DIGIT-1:0] s_o,
  output logic             co_o
);

  always_comb begin
    logic c;
    c   = ci_i;
    s_o = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (a_i[i] & c) | (b_i[i] & c);
    end
    co_o = c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: {cout,sum} = a + b + cin, DIGIT bits per clock, LSB digit first.
// Define DSA_SUB_EN to add a sub input that replaces b with ~b when latched high.
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input logic                clk,
  input logic                rst_n,
  digit_serial_adder_if.slave bus
);

  localparam int unsigned NDIG  = ndig(WIDTH, DIGIT);
  localparam int unsigned CNT_W = cnt_w(NDIG);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $fatal(1, "digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               in_ready, out_valid;
  logic               accept, last_digit;
  logic [WIDTH-1:0]   b_eff;
  logic [DIGIT-1:0]   slice_s;
  logic               slice_co;

  assign accept     = bus.in_valid && (state_q == StIdle);
  assign last_digit = (cnt_q == CNT_W'(NDIG - 1));

`ifdef DSA_SUB_EN
  assign b_eff = bus.sub ? ~bus.b : bus.b;
`else
  assign b_eff = bus.b;
`endif

  // Operands shift right each RUN cycle so the slice always sees the low digit.
  digit_rca #(
    .DIGIT (DIGIT)
  ) u_rca (
    .a_i  (opa_q[DIGIT-1:0]),
    .b_i  (opb_q[DIGIT-1:0]),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StRun;
      StRun:   if (last_digit) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      opa_d   = bus.a;
      opb_d   = b_eff;
      carry_d = bus.cin;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      opa_d   = opa_q >> DIGIT;
      opb_d   = opb_q >> DIGIT;
      carry_d = slice_co;
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          sum_d[i*DIGIT +: DIGIT] = slice_s;
        end
      end
      if (last_digit) begin
        cout_d = slice_co;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule
